// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU operation codes, execute-stage states and default widths.
package cpu_pkg;

  localparam int DATA_W_DEF     = 32;
  localparam int REG_ADDR_W_DEF = 5;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_SLT  = 3'd4,
    ALU_SLL  = 3'd5,
    ALU_MUL  = 3'd6,
    ALU_RSVD = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } exec_state_e;

endpackage

// File: rtl/exec_alu.sv
// Combinational single-cycle ALU with zero flag. MUL and the reserved code both yield 0 here;
// the iterative multiplier lives in exec_stage.
module exec_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [2:0]        aluOp,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  localparam int SHAMT_W = $clog2(DATA_W);

  always_comb begin
    result = '0;
    case (alu_op_e'(aluOp))
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLL: result = a << b[SHAMT_W-1:0];
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/exec_stage.sv
// Registered execute stage: operand/destination select, ALU, valid/ready output register.
// Define EXEC_MUL_EN to add the iterative shift-add multiplier for alu_op 6.
module exec_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     rs_val,
  input  logic [DATA_W-1:0]     rt_val,
  input  logic [DATA_W-1:0]     imm_val,
  input  logic [REG_ADDR_W-1:0] rt_addr,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  input  logic                  reg_dst,
  input  logic                  alu_src,
  input  logic [2:0]            alu_op,
  input  logic                  reg_write_in,
  input  logic                  mem_write_in,
  input  logic                  mem_to_reg_in,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_result,
  output logic [DATA_W-1:0]     out_store_data,
  output logic [REG_ADDR_W-1:0] out_wreg,
  output logic                  out_reg_write,
  output logic                  out_mem_write,
  output logic                  out_mem_to_reg,
  output logic                  out_zero,
  output exec_state_e           dbg_state
);

  // Handshake: a transfer happens on any edge where valid && ready; in_ready never
  // depends on in_valid, and out_valid holds its data stable until out_ready.
  logic [DATA_W-1:0]     opB;
  logic [REG_ADDR_W-1:0] wregSel;
  logic [DATA_W-1:0]     aluResult;
  logic                  aluZero;
  logic                  outFree;
  logic                  accept;

  assign opB     = alu_src ? imm_val : rt_val;
  assign wregSel = reg_dst ? rd_addr : rt_addr;
  assign outFree = !out_valid || out_ready;
  assign accept  = in_valid && in_ready;

  exec_alu #(.DATA_W(DATA_W)) uAlu (
    .aluOp  (alu_op),
    .a      (rs_val),
    .b      (opB),
    .result (aluResult),
    .zero   (aluZero)
  );

`ifdef EXEC_MUL_EN
  localparam int CNT_W = $clog2(DATA_W) + 1;

  exec_state_e       state;
  logic [DATA_W-1:0] mulA;
  logic [DATA_W-1:0] mulB;
  logic [DATA_W-1:0] acc;
  logic [CNT_W-1:0]  mulCnt;
  logic              isMul;

  assign isMul     = (alu_op_e'(alu_op) == ALU_MUL);
  assign in_ready  = (state == ST_IDLE) && outFree && !flush;
  assign dbg_state = state;
`else
  assign in_ready  = outFree && !flush;
  assign dbg_state = ST_IDLE;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid      <= 1'b0;
      out_result     <= '0;
      out_store_data <= '0;
      out_wreg       <= '0;
      out_reg_write  <= 1'b0;
      out_mem_write  <= 1'b0;
      out_mem_to_reg <= 1'b0;
      out_zero       <= 1'b0;
`ifdef EXEC_MUL_EN
      state  <= ST_IDLE;
      mulA   <= '0;
      mulB   <= '0;
      acc    <= '0;
      mulCnt <= '0;
`endif
    end else if (flush) begin
      out_valid <= 1'b0;
`ifdef EXEC_MUL_EN
      state <= ST_IDLE;
`endif
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      // Accept implies the previous result leaves this edge, so passthrough fields
      // may load immediately even for a multiply that finishes later.
      if (accept) begin
        out_store_data <= rt_val;
        out_wreg       <= wregSel;
        out_reg_write  <= reg_write_in;
        out_mem_write  <= mem_write_in;
        out_mem_to_reg <= mem_to_reg_in;
`ifdef EXEC_MUL_EN
        if (isMul) begin
          mulA   <= rs_val;
          mulB   <= opB;
          acc    <= '0;
          mulCnt <= CNT_W'(DATA_W);
          state  <= ST_MUL;
        end else
`endif
        begin
          out_result <= aluResult;
          out_zero   <= aluZero;
          out_valid  <= 1'b1;
        end
      end
`ifdef EXEC_MUL_EN
      case (state)
        ST_MUL: begin
          if (mulB[0]) acc <= acc + mulA;
          mulA   <= mulA << 1;
          mulB   <= mulB >> 1;
          mulCnt <= mulCnt - CNT_W'(1);
          if (mulCnt == CNT_W'(1)) state <= ST_DONE;
        end
        ST_DONE: begin
          if (outFree) begin
            out_result <= acc;
            out_zero   <= (acc == '0);
            out_valid  <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        default: ;
      endcase
`endif
    end
  end

endmodule

// File: tb/tb_exec_stage.sv
// Directed and randomized checks of exec_stage against a behavioural reference model.
module tb_exec_stage;
  import cpu_pkg::*;

  localparam int EW = 73;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] imm_val;
  logic [4:0]  rt_addr;
  logic [4:0]  rd_addr;
  logic        reg_dst;
  logic        alu_src;
  logic [2:0]  alu_op;
  logic        reg_write_in;
  logic        mem_write_in;
  logic        mem_to_reg_in;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [31:0] out_store_data;
  logic [4:0]  out_wreg;
  logic        out_reg_write;
  logic        out_mem_write;
  logic        out_mem_to_reg;
  logic        out_zero;
  exec_state_e dbg_state;

  int tests = 0;
  int fails = 0;
  logic [EW-1:0] exp_q[$];

  exec_stage dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .rs_val         (rs_val),
    .rt_val         (rt_val),
    .imm_val        (imm_val),
    .rt_addr        (rt_addr),
    .rd_addr        (rd_addr),
    .reg_dst        (reg_dst),
    .alu_src        (alu_src),
    .alu_op         (alu_op),
    .reg_write_in   (reg_write_in),
    .mem_write_in   (mem_write_in),
    .mem_to_reg_in  (mem_to_reg_in),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_result     (out_result),
    .out_store_data (out_store_data),
    .out_wreg       (out_wreg),
    .out_reg_write  (out_reg_write),
    .out_mem_write  (out_mem_write),
    .out_mem_to_reg (out_mem_to_reg),
    .out_zero       (out_zero),
    .dbg_state      (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] rt,
                       input logic [31:0] imm, input logic src, input logic dst);
    in_valid = 1'b1;
    alu_op   = op;
    rs_val   = a;
    rt_val   = rt;
    imm_val  = imm;
    alu_src  = src;
    reg_dst  = dst;
  endtask

  // reference arithmetic
  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] prod;
    prod = 64'(a) * 64'(b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd5: return a << (b % 32);
`ifdef EXEC_MUL_EN
      3'd6: return prod[31:0];
`endif
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [EW-1:0] dut_vec();
    return {out_result, out_store_data, out_wreg, out_reg_write, out_mem_write,
            out_mem_to_reg, out_zero};
  endfunction

  initial begin
    int n;
    logic seen;
    logic model_valid;
    logic exp_ready;
    logic acc_now;
    logic [31:0] b_op;
    logic [31:0] res;
    logic [4:0] wr;

    rst = 1'b0; in_valid = 1'b0; rs_val = '0; rt_val = '0; imm_val = '0;
    rt_addr = '0; rd_addr = '0; reg_dst = 1'b0; alu_src = 1'b0; alu_op = '0;
    reg_write_in = 1'b0; mem_write_in = 1'b0; mem_to_reg_in = 1'b0;
    flush = 1'b0; out_ready = 1'b1;

    #1;
    chk("reset_outputs", 80'(dut_vec()), 80'(0));
    chk("reset_valid", 80'(out_valid), 80'(0));
    #21 rst = 1'b1;
    tick();
    chk("post_reset_in_ready", 80'(in_ready), 80'(1));
    chk("post_reset_state", 80'(dbg_state), 80'(ST_IDLE));

    // ADD with immediate, destination rt
    rt_addr = 5'd9; rd_addr = 5'd17; reg_write_in = 1'b1;
    issue(3'd0, 32'h0000_0005, 32'h33, 32'hFFFF_FFFF, 1'b1, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("add_imm_valid", 80'(out_valid), 80'(1));
    chk("add_imm_result", 80'(out_result), 80'(32'h4));
    chk("add_imm_wreg", 80'(out_wreg), 80'(9));
    chk("add_imm_zero", 80'(out_zero), 80'(0));
    chk("add_imm_store", 80'(out_store_data), 80'(32'h33));

    // back-pressure with SUB 7-7
    issue(3'd1, 32'd7, 32'd7, 32'd0, 1'b0, 1'b1);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("sub_result", 80'(out_result), 80'(0));
    chk("sub_zero", 80'(out_zero), 80'(1));
    chk("sub_wreg", 80'(out_wreg), 80'(17));
    chk("bp_in_ready", 80'(in_ready), 80'(0));
    tick();
    tick();
    chk("bp_held_valid", 80'(out_valid), 80'(1));
    chk("bp_held_result", 80'({out_result, out_zero}), 80'({32'd0, 1'b1}));
    issue(3'd3, 32'hF0, 32'h0F, 32'd0, 1'b0, 1'b0);
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 80'(in_ready), 80'(1));
    tick();
    in_valid = 1'b0;
    chk("or_result", 80'(out_result), 80'(32'hFF));
    chk("or_valid", 80'(out_valid), 80'(1));

    // SLT signed, SLL, reserved
    issue(3'd4, 32'hFFFF_FFFE, 32'h1, 32'd0, 1'b0, 1'b0);
    tick();
    chk("slt_signed", 80'(out_result), 80'(1));
    issue(3'd5, 32'h1, 32'h1F, 32'd0, 1'b0, 1'b0);
    tick();
    chk("sll_31", 80'(out_result), 80'(32'h8000_0000));
    issue(3'd7, 32'h1234, 32'h5678, 32'd0, 1'b0, 1'b0);
    tick();
    chk("rsvd_result", 80'({out_result, out_zero}), 80'({32'd0, 1'b1}));

    // MUL
    issue(3'd6, 32'h0001_0003, 32'h0000_0005, 32'd0, 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
`ifdef EXEC_MUL_EN
    n = 0; seen = 1'b0;
    while (!out_valid && n < 100) begin
      if (in_ready) seen = 1'b1;
      tick();
      n++;
    end
    chk("mul_latency", 80'(n), 80'(33));
    chk("mul_in_ready_low", 80'(seen), 80'(0));
    chk("mul_result", 80'(out_result), 80'(32'h0005_000F));
    chk("mul_wreg", 80'(out_wreg), 80'(17));

    // flush 10 cycles into a multiply
    issue(3'd6, 32'h0001_0003, 32'h0000_0005, 32'd0, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    chk("mul_busy_state", 80'(dbg_state), 80'(ST_MUL));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("mul_flush_state", 80'(dbg_state), 80'(ST_IDLE));
    seen = 1'b0;
    repeat (40) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    chk("mul_flush_no_valid", 80'(seen), 80'(0));
`else
    chk("mul_off_valid", 80'(out_valid), 80'(1));
    chk("mul_off_result", 80'({out_result, out_zero}), 80'({32'd0, 1'b1}));
    tick();
`endif

    // flush in the same cycle as an accept, with a held result pending
    issue(3'd0, 32'd1, 32'd2, 32'd0, 1'b0, 1'b0);
    out_ready = 1'b0;
    tick();
    chk("pre_flush_valid", 80'(out_valid), 80'(1));
    issue(3'd0, 32'd5, 32'd6, 32'd0, 1'b0, 1'b0);
    flush = 1'b1;
    #1;
    chk("flush_in_ready", 80'(in_ready), 80'(0));
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("flush_drop_valid", 80'(out_valid), 80'(0));
    chk("flush_state", 80'(dbg_state), 80'(ST_IDLE));
    issue(3'd0, 32'd10, 32'd20, 32'd0, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("after_flush_add", 80'({out_valid, out_result}), 80'({1'b1, 32'd30}));
    tick();

    // randomized stream against the reference model
    model_valid = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      alu_op = 3'($urandom_range(0, 7));
`ifdef EXEC_MUL_EN
      if (alu_op == 3'd6) alu_op = 3'd7;
`endif
      in_valid      = ($urandom_range(0, 3) != 0);
      out_ready     = ($urandom_range(0, 3) != 0);
      flush         = ($urandom_range(0, 31) == 0);
      rs_val        = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      rt_val        = ($urandom_range(0, 3) == 0) ? rs_val : $urandom;
      imm_val       = $urandom;
      alu_src       = 1'($urandom_range(0, 1));
      reg_dst       = 1'($urandom_range(0, 1));
      rt_addr       = 5'($urandom_range(0, 31));
      rd_addr       = 5'($urandom_range(0, 31));
      reg_write_in  = 1'($urandom_range(0, 1));
      mem_write_in  = 1'($urandom_range(0, 1));
      mem_to_reg_in = 1'($urandom_range(0, 1));
      #1;
      exp_ready = !flush && (!model_valid || out_ready);
      chk("rnd_in_ready", 80'(in_ready), 80'(exp_ready));
      chk("rnd_out_valid", 80'(out_valid), 80'(model_valid));
      if (model_valid && out_ready && exp_q.size() > 0)
        chk("rnd_result", 80'(dut_vec()), 80'(exp_q[0]));
      if (model_valid && (out_ready || flush) && exp_q.size() > 0)
        void'(exp_q.pop_front());
      acc_now = in_valid && exp_ready;
      if (acc_now) begin
        b_op = alu_src ? imm_val : rt_val;
        res  = ref_alu(alu_op, rs_val, b_op);
        wr   = reg_dst ? rd_addr : rt_addr;
        exp_q.push_back({res, rt_val, wr, reg_write_in, mem_write_in, mem_to_reg_in,
                         (res == 32'd0)});
      end
      if (flush) model_valid = 1'b0;
      else if (acc_now) model_valid = 1'b1;
      else if (model_valid && out_ready) model_valid = 1'b0;
      tick();
    end
    in_valid = 1'b0; flush = 1'b0;

    // reset mid-stream while a result is held
    issue(3'd0, 32'd3, 32'd4, 32'd0, 1'b0, 1'b0);
    reg_write_in = 1'b1;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("pre_reset_valid", 80'(out_valid), 80'(1));
    #2 rst = 1'b0;
    #1;
    chk("async_reset_valid", 80'(out_valid), 80'(0));
    chk("async_reset_outputs", 80'(dut_vec()), 80'(0));
    #3 rst = 1'b1;
    tick();
    chk("after_reset_in_ready", 80'(in_ready), 80'(1));
    chk("after_reset_state", 80'(dbg_state), 80'(ST_IDLE));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
